// File: rtl/k_and_s_pkg.sv
// Shared opcode values, decoded instruction types and the opcode decode table.
package k_and_s_pkg;

  localparam int unsigned OPC_W = 8;

  localparam logic [OPC_W-1:0] OPC_NOP    = 8'h00;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 8'h81;
  localparam logic [OPC_W-1:0] OPC_STORE  = 8'h82;
  localparam logic [OPC_W-1:0] OPC_MOVE   = 8'h91;
  localparam logic [OPC_W-1:0] OPC_ADD    = 8'hA1;
  localparam logic [OPC_W-1:0] OPC_SUB    = 8'hA2;
  localparam logic [OPC_W-1:0] OPC_AND    = 8'hA3;
  localparam logic [OPC_W-1:0] OPC_OR     = 8'hA4;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 8'h01;
  localparam logic [OPC_W-1:0] OPC_BZERO  = 8'h02;
  localparam logic [OPC_W-1:0] OPC_BNZERO = 8'h0B;
  localparam logic [OPC_W-1:0] OPC_BNEG   = 8'h03;
  localparam logic [OPC_W-1:0] OPC_BNNEG  = 8'h0A;
  localparam logic [OPC_W-1:0] OPC_BOV    = 8'h04;
  localparam logic [OPC_W-1:0] OPC_BNOV   = 8'h05;
  localparam logic [OPC_W-1:0] OPC_HALT   = 8'hFF;

  typedef enum logic [4:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;

  typedef struct packed {
    decoded_instruction_type op;
    logic                    illegal;
  } decode_result_t;

  // Map an 8-bit opcode to its instruction type; unknown opcodes become an illegal NOP.
  function automatic decode_result_t decode_opcode(input logic [OPC_W-1:0] opc);
    decode_result_t res;
    res.op      = I_NOP;
    res.illegal = 1'b0;
    case (opc)
      OPC_NOP:    res.op = I_NOP;
      OPC_LOAD:   res.op = I_LOAD;
      OPC_STORE:  res.op = I_STORE;
      OPC_MOVE:   res.op = I_MOVE;
      OPC_ADD:    res.op = I_ADD;
      OPC_SUB:    res.op = I_SUB;
      OPC_AND:    res.op = I_AND;
      OPC_OR:     res.op = I_OR;
      OPC_BRANCH: res.op = I_BRANCH;
      OPC_BZERO:  res.op = I_BZERO;
      OPC_BNZERO: res.op = I_BNZERO;
      OPC_BNEG:   res.op = I_BNEG;
      OPC_BNNEG:  res.op = I_BNNEG;
      OPC_BOV:    res.op = I_BOV;
      OPC_BNOV:   res.op = I_BNOV;
      OPC_HALT:   res.op = I_HALT;
      default:    res.illegal = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/k_and_s_opcode_lut.sv
// Combinational opcode lookup, kept separate so the table can be exercised on its own.
module k_and_s_opcode_lut
  import k_and_s_pkg::*;
(
  input  logic [OPC_W-1:0]        opcode,
  output decoded_instruction_type op_c,
  output logic                    illegal_c
);

  decode_result_t res;

  // Table lookup.
  always_comb res = decode_opcode(opcode);

  assign op_c      = res.op;
  assign illegal_c = res.illegal;

endmodule

// File: rtl/k_and_s_decode_stage.sv
// K&S decode stage: opcode/field decode into a 2-entry skid buffer with HALT latching.
module k_and_s_decode_stage
  import k_and_s_pkg::*;
#(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned REG_AW  = 2,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         out_op,
  output logic [REG_AW-1:0]  out_ra,
  output logic [REG_AW-1:0]  out_rb,
  output logic [REG_AW-1:0]  out_rc,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               out_illegal,
  output logic               halted,
  output logic [CNT_W-1:0]   dec_count
);

  typedef struct packed {
    decoded_instruction_type op;
    logic [REG_AW-1:0]       ra;
    logic [REG_AW-1:0]       rb;
    logic [REG_AW-1:0]       rc;
    logic [ADDR_W-1:0]       addr;
    logic                    illegal;
  } decoded_entry_t;

  decoded_entry_t          ent0, ent1, ent0_n, ent1_n, new_ent;
  logic [1:0]              cnt, cnt_n;
  logic                    halt_pending, halt_pending_n;
  logic                    halted_q, halted_n;
  logic [CNT_W-1:0]        dec_count_q, dec_count_n;
  logic                    in_ready_q, in_ready_n;
  logic                    out_valid_q, out_valid_n;
  logic                    push, pop;
  decoded_instruction_type lut_op;
  logic                    lut_illegal;
  logic                    unused_bits;

  k_and_s_opcode_lut u_lut (
    .opcode    (in_instr[INSTR_W-1 -: OPC_W]),
    .op_c      (lut_op),
    .illegal_c (lut_illegal)
  );

  // Bits between the register fields and the opcode carry no meaning for decode.
  assign unused_bits = ^in_instr;

  // Assemble the decoded entry from the incoming word; field extraction is unconditional.
  always_comb begin
    new_ent.op      = lut_op;
    new_ent.illegal = lut_illegal;
    new_ent.ra      = in_instr[3*REG_AW-1 -: REG_AW];
    new_ent.rb      = in_instr[2*REG_AW-1 -: REG_AW];
    new_ent.rc      = in_instr[REG_AW-1:0];
    new_ent.addr    = in_instr[ADDR_W-1:0];
  end

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  // Next-state for buffer, halt latch and counter; flush overrides any push/pop.
  always_comb begin
    ent0_n         = ent0;
    ent1_n         = ent1;
    cnt_n          = cnt;
    halt_pending_n = halt_pending;
    halted_n       = halted_q;
    dec_count_n    = dec_count_q;
    if (flush) begin
      cnt_n          = 2'd0;
      halt_pending_n = 1'b0;
      halted_n       = 1'b0;
    end else begin
      if (pop) begin
        dec_count_n = dec_count_q + CNT_W'(1);
        if (ent0.op == I_HALT) halted_n = 1'b1;
      end
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0_n = new_ent;
          else             ent1_n = new_ent;
          cnt_n = cnt + 2'd1;
        end
        2'b01: begin
          ent0_n = ent1;
          cnt_n  = cnt - 2'd1;
        end
        // Only reachable with one entry held: the new word replaces the departing head.
        2'b11:   ent0_n = new_ent;
        default: ;
      endcase
      if (push && (new_ent.op == I_HALT)) halt_pending_n = 1'b1;
    end
    in_ready_n  = !halt_pending_n && (cnt_n < 2'd2);
    out_valid_n = (cnt_n != 2'd0);
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0         <= '0;
      ent1         <= '0;
      cnt          <= 2'd0;
      halt_pending <= 1'b0;
      halted_q     <= 1'b0;
      dec_count_q  <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      ent0         <= ent0_n;
      ent1         <= ent1_n;
      cnt          <= cnt_n;
      halt_pending <= halt_pending_n;
      halted_q     <= halted_n;
      dec_count_q  <= dec_count_n;
      in_ready_q   <= in_ready_n;
      out_valid_q  <= out_valid_n;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_op      = ent0.op;
  assign out_ra      = ent0.ra;
  assign out_rb      = ent0.rb;
  assign out_rc      = ent0.rc;
  assign out_addr    = ent0.addr;
  assign out_illegal = ent0.illegal;
  assign halted      = halted_q;
  assign dec_count   = dec_count_q;

endmodule

// File: tb/tb_k_and_s_decode_stage.sv
// Bench for k_and_s_decode_stage: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_k_and_s_decode_stage;
  import k_and_s_pkg::*;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned REG_AW  = 2;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic [INSTR_W-1:0] in_instr = '0;
  logic               in_ready, out_valid, out_illegal, halted;
  logic [4:0]         out_op;
  logic [REG_AW-1:0]  out_ra, out_rb, out_rc;
  logic [ADDR_W-1:0]  out_addr;
  logic [CNT_W-1:0]   dec_count;

  k_and_s_decode_stage #(
    .INSTR_W(INSTR_W), .REG_AW(REG_AW), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_ra(out_ra), .out_rb(out_rb), .out_rc(out_rc),
    .out_addr(out_addr), .out_illegal(out_illegal),
    .halted(halted), .dec_count(dec_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference decode table: returns {illegal, op}.
  function automatic logic [5:0] ref_decode(input logic [7:0] o);
    case (o)
      8'h00: return {1'b0, I_NOP};
      8'h81: return {1'b0, I_LOAD};
      8'h82: return {1'b0, I_STORE};
      8'h91: return {1'b0, I_MOVE};
      8'hA1: return {1'b0, I_ADD};
      8'hA2: return {1'b0, I_SUB};
      8'hA3: return {1'b0, I_AND};
      8'hA4: return {1'b0, I_OR};
      8'h01: return {1'b0, I_BRANCH};
      8'h02: return {1'b0, I_BZERO};
      8'h0B: return {1'b0, I_BNZERO};
      8'h03: return {1'b0, I_BNEG};
      8'h0A: return {1'b0, I_BNNEG};
      8'h04: return {1'b0, I_BOV};
      8'h05: return {1'b0, I_BNOV};
      8'hFF: return {1'b0, I_HALT};
      default: return {1'b1, I_NOP};
    endcase
  endfunction

  // Model state: queue of raw accepted words, halt flags, pop count, registered-ready view.
  logic [INSTR_W-1:0] mq[$];
  bit                 m_hp, m_halted, m_rdy;
  int unsigned        m_cnt;

  // Reference model advances on each clock edge; any reset empties it.
  initial begin
    m_hp = 0; m_halted = 0; m_rdy = 0; m_cnt = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_hp = 0; m_halted = 0; m_rdy = 0; m_cnt = 0;
      end else begin
        bit push, pop;
        logic [INSTR_W-1:0] head;
        push = in_valid && m_rdy;
        pop  = (mq.size() > 0) && out_ready;
        if (flush) begin
          mq.delete();
          m_hp = 0; m_halted = 0; m_rdy = 1;
        end else begin
          if (pop) begin
            head = mq.pop_front();
            if (head[15:8] == 8'hFF) m_halted = 1;
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
          end
          if (push) begin
            mq.push_back(in_instr);
            if (in_instr[15:8] == 8'hFF) m_hp = 1;
          end
          m_rdy = !m_hp && (mq.size() < 2);
        end
      end
    end
  end

  // Compare DUT against the model every falling edge outside reset.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        logic [INSTR_W-1:0] e;
        logic [5:0] d;
        int ev;
        check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        check("in_ready", 32'(in_ready), 32'(m_rdy));
        check("halted", 32'(halted), 32'(m_halted));
        check("dec_count", 32'(dec_count), 32'(m_cnt));
        if (mq.size() > 0) begin
          e  = mq[0];
          ev = int'(e);
          d  = ref_decode(e[15:8]);
          check("out_op", 32'(out_op), 32'(d[4:0]));
          check("out_illegal", 32'(out_illegal), 32'(d[5]));
          check("out_ra", 32'(out_ra), 32'((ev / 16) % 4));
          check("out_rb", 32'(out_rb), 32'((ev / 4) % 4));
          check("out_rc", 32'(out_rc), 32'(ev % 4));
          check("out_addr", 32'(out_addr), 32'(ev % 32));
        end
      end
    end
  end

  // One clock of stimulus; returns just after the following falling edge.
  task automatic cyc(input bit v, input logic [INSTR_W-1:0] w, input bit r, input bit f);
    in_valid = v; in_instr = w; out_ready = r; flush = f;
    @(negedge clk); #1;
  endtask

  // Asynchronous reset pulse starting between edges.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dec_count", 32'(dec_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  logic [7:0] opc_tab [16] = '{8'h00, 8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
                               8'h01, 8'h02, 8'h0B, 8'h03, 8'h0A, 8'h04, 8'h05, 8'hFF};

  initial begin
    // Reset applied before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_dec_count", 32'(dec_count), 32'd0);
    check("reset_out_op", 32'(out_op), 32'(I_NOP));
    check("reset_fields", 32'({out_ra, out_rb, out_rc, out_addr, out_illegal}), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    cyc(0, '0, 0, 0);
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // ADD with fields ra=1 rb=2 rc=3.
    cyc(1, 16'hA11B, 1, 0);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_op", 32'(out_op), 32'(I_ADD));
    check("add_regs", 32'({out_ra, out_rb, out_rc}), 32'({2'd1, 2'd2, 2'd3}));
    cyc(0, '0, 1, 0);
    check("add_count", 32'(dec_count), 32'd1);

    // Fill buffer while stalled, then drain in order.
    cyc(1, 16'h8105, 0, 0);
    cyc(1, 16'h821F, 0, 0);
    check("full_not_ready", 32'(in_ready), 32'd0);
    check("load_head", 32'({out_op, out_addr}), 32'({I_LOAD, 5'd5}));
    cyc(1, 16'h0107, 0, 0);
    check("stall_hold", 32'({out_op, out_addr}), 32'({I_LOAD, 5'd5}));
    cyc(1, 16'h0107, 1, 0);
    check("store_head", 32'({out_op, out_addr}), 32'({I_STORE, 5'd31}));
    cyc(1, 16'h0107, 1, 0);
    check("branch_head", 32'({out_op, out_addr}), 32'({I_BRANCH, 5'd7}));
    cyc(0, '0, 1, 0);

    // Illegal opcode passes through.
    cyc(1, 16'h5500, 1, 0);
    check("illegal_op", 32'({out_op, out_illegal}), 32'({I_NOP, 1'b1}));
    cyc(0, '0, 1, 0);
    check("illegal_count", 32'(dec_count), 32'd5);

    // HALT blocks the following SUB, then flush recovers.
    cyc(1, 16'hFF00, 1, 0);
    check("halt_blocks_ready", 32'(in_ready), 32'd0);
    cyc(1, 16'hA200, 1, 0);
    check("halted_set", 32'(halted), 32'd1);
    check("sub_not_taken", 32'(out_valid), 32'd0);
    cyc(1, 16'hA200, 1, 0);
    cyc(1, 16'hA200, 1, 0);
    check("sub_still_blocked", 32'(out_valid), 32'd0);
    cyc(0, '0, 0, 1);
    check("flush_halted", 32'(halted), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    check("flush_keeps_count", 32'(dec_count), 32'd6);

    // Async reset with two entries buffered.
    cyc(1, 16'hA31B, 0, 0);
    cyc(1, 16'hA40F, 0, 0);
    async_reset();

    // Counter wrap: 17 pops on a 4-bit counter.
    cyc(0, '0, 1, 0);
    for (int i = 0; i < 17; i++) cyc(1, 16'hA11B, 1, 0);
    cyc(0, '0, 1, 0);
    check("count_wrap", 32'(dec_count), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] opc;
      if ($urandom_range(0, 599) == 0) async_reset();
      opc = ($urandom_range(0, 9) < 8) ? opc_tab[$urandom_range(0, 15)] : 8'($urandom);
      cyc($urandom_range(0, 99) < 70, {opc, 8'($urandom)}, $urandom_range(0, 99) < 65,
          $urandom_range(0, 99) < 3);
    end
    cyc(0, '0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
